sevenseg_scan_driver: RTL and testbench

//  Reader/display end of the stopwatch counter's digit interface. Samples the four BCD

---
 rtl/sevenseg_scan_driver.sv | 111 +++++++++++
 tb/tb_sevenseg_scan_driver.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_driver.sv
// rtl/sevenseg_scan_driver.sv - 4-digit common-anode 7-segment scan driver with frame snapshot and field blink
module sevenseg_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] minutes_1,
    input  logic [3:0] minutes_0,
    input  logic [3:0] seconds_1,
    input  logic [3:0] seconds_0,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_snap;
    logic [BW-1:0] r_bcnt;
    logic          r_boff;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_tick;
    logic          w_btc;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg_raw;
    logic          w_blank;
    logic [3:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;

    assign w_tick = (r_cnt == RW'(REFRESH_DIV - 1));
    assign w_btc  = (r_bcnt == BW'(BLINK_DIV - 1));

    always_comb begin
        w_digit   = r_snap[3:0];
        w_seg_raw = 7'h3F;
        case (r_idx)
            2'd0: w_digit = r_snap[3:0];
            2'd1: w_digit = r_snap[7:4];
            2'd2: w_digit = r_snap[11:8];
            2'd3: w_digit = r_snap[15:12];
            default: w_digit = r_snap[3:0];
        endcase
        case (w_digit)
            4'd0: w_seg_raw = 7'h40;
            4'd1: w_seg_raw = 7'h79;
            4'd2: w_seg_raw = 7'h24;
            4'd3: w_seg_raw = 7'h30;
            4'd4: w_seg_raw = 7'h19;
            4'd5: w_seg_raw = 7'h12;
            4'd6: w_seg_raw = 7'h02;
            4'd7: w_seg_raw = 7'h78;
            4'd8: w_seg_raw = 7'h00;
            4'd9: w_seg_raw = 7'h10;
            default: w_seg_raw = 7'h3F;
        endcase
        // Gating with adj makes the output unblank on the same edge adj drops.
        w_blank = adj && r_boff && (sel ? ~r_idx[1] : r_idx[1]);
        w_an    = ~(4'b0001 << r_idx);
        w_seg   = w_blank ? 7'h7F : w_seg_raw;
        w_dp    = w_blank ? 1'b1 : (r_idx != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_idx  <= 2'd0;
            r_snap <= 16'h0000;
            r_bcnt <= '0;
            r_boff <= 1'b0;
            r_an   <= 4'hF;
            r_seg  <= 7'h7F;
            r_dp   <= 1'b1;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end
            // Load only at frame boundary so one frame never mixes old and new digits.
            if (w_tick && (r_idx == 2'd3)) begin
                r_snap <= {minutes_1, minutes_0, seconds_1, seconds_0};
            end
            if (!adj) begin
                r_bcnt <= '0;
                r_boff <= 1'b0;
            end else if (w_btc) begin
                r_bcnt <= '0;
                r_boff <= ~r_boff;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb/tb_sevenseg_scan_driver.sv - table-driven bench for sevenseg_scan_driver
module tb_sevenseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dig = 16'h1234;
    logic        adj = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int errors = 0;
    int checks = 0;
    int k = 0;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .minutes_1 (dig[15:12]),
        .minutes_0 (dig[11:8]),
        .seconds_1 (dig[7:4]),
        .seconds_0 (dig[3:0]),
        .adj       (adj),
        .sel       (sel),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    typedef struct {
        bit          rst_before;
        int          k;
        logic [15:0] dig;
        logic        adj;
        logic        sel;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit rb, input int kk, input logic [15:0] d, input logic a,
                       input logic s, input logic [3:0] ean, input logic [6:0] eseg, input logic edp);
        vec_t v;
        v.rst_before = rb; v.k = kk; v.dig = d; v.adj = a; v.sel = s;
        v.an = ean; v.seg = eseg; v.dp = edp;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int kk, input logic [3:0] ean,
                       input logic [6:0] eseg, input logic edp);
        checks++;
        if (an !== ean) begin
            errors++;
            $display("FAIL %s k=%0d an: got %h expected %h", nm, kk, an, ean);
        end
        checks++;
        if (seg !== eseg) begin
            errors++;
            $display("FAIL %s k=%0d seg: got %h expected %h", nm, kk, seg, eseg);
        end
        checks++;
        if (dp !== edp) begin
            errors++;
            $display("FAIL %s k=%0d dp: got %b expected %b", nm, kk, dp, edp);
        end
    endtask

    initial begin
        // frame 0 shows reset snapshot, frame 1 shows 1234
        add(0,  1, 16'h1234, 0, 0, 4'hE, 7'h40, 1);
        add(0,  5, 16'h1234, 0, 0, 4'hD, 7'h40, 1);
        add(0,  9, 16'h1234, 0, 0, 4'hB, 7'h40, 0);
        add(0, 13, 16'h1234, 0, 0, 4'h7, 7'h40, 1);
        add(0, 16, 16'h1234, 0, 0, 4'h7, 7'h40, 1);
        add(0, 17, 16'h1234, 0, 0, 4'hE, 7'h19, 1);
        add(0, 21, 16'h1234, 0, 0, 4'hD, 7'h30, 1);
        add(0, 25, 16'h5239, 0, 0, 4'hB, 7'h24, 0);
        add(0, 28, 16'h5239, 0, 0, 4'hB, 7'h24, 0);
        add(0, 29, 16'h52C9, 0, 0, 4'h7, 7'h79, 1);
        add(0, 32, 16'h52C9, 0, 0, 4'h7, 7'h79, 1);
        add(0, 33, 16'h52C9, 0, 0, 4'hE, 7'h10, 1);
        add(0, 37, 16'h52C9, 0, 0, 4'hD, 7'h3F, 1);
        add(0, 40, 16'h52C9, 1, 1, 4'hD, 7'h3F, 1);
        // blink seconds: edges 41..48 normal, 49..56 blanked
        add(0, 41, 16'h52C9, 1, 1, 4'hB, 7'h24, 0);
        add(0, 45, 16'h52C9, 1, 1, 4'h7, 7'h12, 1);
        add(0, 48, 16'h52C9, 1, 1, 4'h7, 7'h12, 1);
        add(0, 49, 16'h52C9, 1, 1, 4'hE, 7'h7F, 1);
        add(0, 53, 16'h52C9, 1, 1, 4'hD, 7'h7F, 1);
        add(0, 54, 16'h52C9, 0, 1, 4'hD, 7'h7F, 1);
        add(0, 55, 16'h52C9, 0, 1, 4'hD, 7'h3F, 1);
        add(0, 57, 16'h52C9, 1, 1, 4'hB, 7'h24, 0);
        // second blink: off phase on edges 66..73, sel flips to minutes mid-phase
        add(0, 58, 16'h52C9, 1, 1, 4'hB, 7'h24, 0);
        add(0, 66, 16'h52C9, 1, 1, 4'hE, 7'h7F, 1);
        add(0, 69, 16'h52C9, 1, 0, 4'hD, 7'h7F, 1);
        add(0, 70, 16'h52C9, 1, 0, 4'hD, 7'h3F, 1);
        add(0, 73, 16'h52C9, 1, 0, 4'hB, 7'h7F, 1);
        add(0, 74, 16'h1234, 0, 0, 4'hB, 7'h24, 0);
        add(0, 77, 16'h1234, 0, 0, 4'h7, 7'h12, 1);
        // reset pulsed while idx=3: 0000 until the first wrap
        add(1,  1, 16'h1234, 0, 0, 4'hE, 7'h40, 1);
        add(0,  9, 16'h1234, 0, 0, 4'hB, 7'h40, 0);
        add(0, 16, 16'h1234, 0, 0, 4'h7, 7'h40, 1);
        add(0, 17, 16'h1234, 0, 0, 4'hE, 7'h19, 1);
        add(0, 29, 16'h1234, 0, 0, 4'h7, 7'h79, 1);

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_hold", 0, 4'hF, 7'h7F, 1'b1);
        rst = 1'b0;
        k = 0;

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst_before) begin
                rst = 1'b1;
                tick();
                chk("reset_mid", k, 4'hF, 7'h7F, 1'b1);
                rst = 1'b0;
                k = 0;
            end
            if (vq[i].k <= k) begin
                errors++;
                checks++;
                $display("FAIL table_order vec=%0d k=%0d target=%0d", i, k, vq[i].k);
            end
            while (k < vq[i].k) tick();
            chk($sformatf("vec%0d", i), k, vq[i].an, vq[i].seg, vq[i].dp);
            dig = vq[i].dig;
            adj = vq[i].adj;
            sel = vq[i].sel;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
